spi_eeprom_responder: RTL and testbench

//  SPI mode-0 responder emulating a 25xx-style serial EEPROM (8-bit address) so the

---
 rtl/spi_eeprom_responder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_spi_eeprom_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder
// SPI mode-0 responder that behaves like a small 25xx-style serial EEPROM with
// an 8-bit address. Supports READ, WRITE, WREN, WRDI and RDSR against an
// internal byte array. All SPI pins are asynchronous to clk and are
// synchronised before any edge detection.

module spi_eeprom_responder #(
    parameter int MEM_DEPTH   = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic wel,
    output logic wr_strobe,
    output logic cmd_err
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_STATUS  = 3'd5,
        ST_DONE    = 3'd6,
        ST_IGNORE  = 3'd7
    } state_t;

    // Synchroniser chains and previous-value flops for edge detection
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   cs_prev_r;
    logic                   sclk_prev_r;

    logic cs_s, sclk_s, mosi_s;
    logic cs_rise_s, cs_fall_s, sclk_rise_s, sclk_fall_s;

    // FSM / datapath state and its next values
    state_t        state_r,      state_next_s;
    logic [2:0]    bit_cnt_r,    bit_cnt_next_s;
    logic [7:0]    shift_r,      shift_next_s;
    logic [7:0]    tx_r,         tx_next_s;
    logic [AW-1:0] addr_r,       addr_next_s;
    logic          is_read_r,    is_read_next_s;
    logic          committed_r,  committed_next_s;
    logic          done_wren_r,  done_wren_next_s;
    logic          extra_r,      extra_next_s;
    logic          miso_r,       miso_next_s;
    logic          oe_r,         oe_next_s;
    logic          wel_r,        wel_next_s;
    logic          wr_strobe_r,  wr_strobe_next_s;
    logic          cmd_err_r,    cmd_err_next_s;

    logic          mem_we_s;
    logic [7:0]    rx_byte_s;
    logic [7:0]    rd_byte_s;

    // Storage array; deliberately not reset so contents survive nreset
    logic [7:0]    mem_r [MEM_DEPTH];

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // sclk edges only count while chip select is low
    assign cs_fall_s   =  cs_prev_r & ~cs_s;
    assign cs_rise_s   = ~cs_prev_r &  cs_s;
    assign sclk_rise_s = ~sclk_prev_r &  sclk_s & ~cs_s;
    assign sclk_fall_s =  sclk_prev_r & ~sclk_s & ~cs_s;

    assign rx_byte_s = {shift_r[6:0], mosi_s};
    assign rd_byte_s = (state_r == ST_STATUS) ? {6'b000000, wel_r, 1'b0} : mem_r[addr_r];

    assign spi_miso    = miso_r;
    assign spi_miso_oe = oe_r;
    assign wel         = wel_r;
    assign wr_strobe   = wr_strobe_r;
    assign cmd_err     = cmd_err_r;

    // Bring the asynchronous SPI pins into the clk domain and keep last values
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_prev_r   <= 1'b1;
            sclk_prev_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_r   <= cs_s;
            sclk_prev_r <= sclk_s;
        end
    end

    // Register FSM state, datapath and outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            tx_r        <= 8'h00;
            addr_r      <= '0;
            is_read_r   <= 1'b0;
            committed_r <= 1'b0;
            done_wren_r <= 1'b0;
            extra_r     <= 1'b0;
            miso_r      <= 1'b0;
            oe_r        <= 1'b0;
            wel_r       <= 1'b0;
            wr_strobe_r <= 1'b0;
            cmd_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            shift_r     <= shift_next_s;
            tx_r        <= tx_next_s;
            addr_r      <= addr_next_s;
            is_read_r   <= is_read_next_s;
            committed_r <= committed_next_s;
            done_wren_r <= done_wren_next_s;
            extra_r     <= extra_next_s;
            miso_r      <= miso_next_s;
            oe_r        <= oe_next_s;
            wel_r       <= wel_next_s;
            wr_strobe_r <= wr_strobe_next_s;
            cmd_err_r   <= cmd_err_next_s;
        end
    end

    // Commit a received data byte; the write enable is only raised by the FSM
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= rx_byte_s;
        end else begin
            mem_r[addr_r] <= mem_r[addr_r];
        end
    end

    // Next-state and output logic; cs_n rise outranks cs_n fall outranks sclk
    always_comb begin
        state_next_s     = state_r;
        bit_cnt_next_s   = bit_cnt_r;
        shift_next_s     = shift_r;
        tx_next_s        = tx_r;
        addr_next_s      = addr_r;
        is_read_next_s   = is_read_r;
        committed_next_s = committed_r;
        done_wren_next_s = done_wren_r;
        extra_next_s     = extra_r;
        miso_next_s      = miso_r;
        oe_next_s        = oe_r;
        wel_next_s       = wel_r;
        wr_strobe_next_s = 1'b0;
        cmd_err_next_s   = 1'b0;
        mem_we_s         = 1'b0;

        if (cs_rise_s) begin
            state_next_s   = ST_IDLE;
            bit_cnt_next_s = 3'd0;
            shift_next_s   = 8'h00;
            miso_next_s    = 1'b0;
            oe_next_s      = 1'b0;
            // WREN/WRDI take effect only for an exact 8-bit transaction
            if (state_r == ST_DONE && !extra_r) begin
                wel_next_s = done_wren_r;
            end else if (state_r == ST_WR_DATA && committed_r) begin
                wel_next_s = 1'b0;
            end else begin
                wel_next_s = wel_r;
            end
        end else if (cs_fall_s) begin
            state_next_s     = ST_CMD;
            bit_cnt_next_s   = 3'd0;
            shift_next_s     = 8'h00;
            miso_next_s      = 1'b0;
            oe_next_s        = 1'b0;
            committed_next_s = 1'b0;
            extra_next_s     = 1'b0;
        end else if (sclk_rise_s) begin
            case (state_r)
                ST_CMD: begin
                    shift_next_s = rx_byte_s;
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_next_s = 3'd0;
                        case (rx_byte_s)
                            OP_READ: begin
                                is_read_next_s = 1'b1;
                                state_next_s   = ST_ADDR;
                            end
                            OP_WRITE: begin
                                is_read_next_s = 1'b0;
                                if (wel_r) begin
                                    state_next_s = ST_ADDR;
                                end else begin
                                    state_next_s   = ST_IGNORE;
                                    cmd_err_next_s = 1'b1;
                                end
                            end
                            OP_WREN: begin
                                done_wren_next_s = 1'b1;
                                state_next_s     = ST_DONE;
                            end
                            OP_WRDI: begin
                                done_wren_next_s = 1'b0;
                                state_next_s     = ST_DONE;
                            end
                            OP_RDSR: begin
                                state_next_s = ST_STATUS;
                            end
                            default: begin
                                state_next_s   = ST_IGNORE;
                                cmd_err_next_s = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_ADDR: begin
                    shift_next_s = rx_byte_s;
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_next_s = 3'd0;
                        addr_next_s    = rx_byte_s[AW-1:0];
                        state_next_s   = is_read_r ? ST_RD_DATA : ST_WR_DATA;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_WR_DATA: begin
                    shift_next_s = rx_byte_s;
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_next_s   = 3'd0;
                        mem_we_s         = 1'b1;
                        wr_strobe_next_s = 1'b1;
                        committed_next_s = 1'b1;
                        addr_next_s      = addr_r + AW'(1);
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    extra_next_s = 1'b1;
                end
                default: begin
                    state_next_s = state_r;
                end
            endcase
        end else if (sclk_fall_s) begin
            case (state_r)
                ST_RD_DATA, ST_STATUS: begin
                    oe_next_s = 1'b1;
                    if (bit_cnt_r == 3'd0) begin
                        miso_next_s    = rd_byte_s[7];
                        tx_next_s      = {rd_byte_s[6:0], 1'b0};
                        bit_cnt_next_s = 3'd1;
                    end else begin
                        miso_next_s    = tx_r[7];
                        tx_next_s      = {tx_r[6:0], 1'b0};
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                        // Last bit of a byte is now on the wire: advance address
                        if (bit_cnt_r == 3'd7 && state_r == ST_RD_DATA) begin
                            addr_next_s = addr_r + AW'(1);
                        end else begin
                            addr_next_s = addr_r;
                        end
                    end
                end
                default: begin
                    state_next_s = state_r;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb_spi_eeprom_responder
// Directed bench for spi_eeprom_responder: drives SPI mode-0 transactions from
// tasks and compares against hand-computed values.

module tb_spi_eeprom_responder;

    localparam int HALF = 60;   // half SCLK period in ns (clk period 10 ns)

    logic clk;
    logic nreset;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;
    logic wel;
    logic wr_strobe;
    logic cmd_err;

    int n_cmp;
    int n_err;
    int wr_cnt;
    int err_cnt;
    logic oe_or;
    logic oe_and;

    spi_eeprom_responder #(
        .MEM_DEPTH  (128),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .wel        (wel),
        .wr_strobe  (wr_strobe),
        .cmd_err    (cmd_err)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count single-cycle pulses mid-cycle
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;
        if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs_n = 1'b1;
        #(HALF * 2);
    endtask

    // Shift nbits of tx out MSB first; rx collects MISO sampled at each rise
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #HALF;
            spi_sclk = 1'b1;
            rx = {rx[6:0], spi_miso};
            oe_or  = oe_or | spi_miso_oe;
            oe_and = oe_and & spi_miso_oe;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cmd_only(input logic [7:0] op);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(op, 8, rx);
        cs_end();
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(addr, 8, rx);
        spi_xfer(d0, 8, rx);
        if (n > 1) spi_xfer(d1, 8, rx);
        cs_end();
    endtask

    task automatic spi_read2(input logic [7:0] op, input logic [7:0] addr,
                             output logic [7:0] r0, output logic [7:0] r1);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(op, 8, rx);
        if (op == 8'h03) spi_xfer(addr, 8, rx);
        oe_and = 1'b1;
        oe_or  = 1'b0;
        spi_xfer(8'h00, 8, r0);
        spi_xfer(8'h00, 8, r1);
        cs_end();
    endtask

    initial begin
        logic [7:0] r0, r1, rx;
        int w0, e0;
        n_cmp    = 0;
        n_err    = 0;
        wr_cnt   = 0;
        err_cnt  = 0;
        oe_or    = 1'b0;
        oe_and   = 1'b1;
        nreset   = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_miso", {31'd0, spi_miso}, 32'd0);
        check_val("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check_val("rst_wel", {31'd0, wel}, 32'd0);
        check_val("rst_wrs", {31'd0, wr_strobe}, 32'd0);
        check_val("rst_err", {31'd0, cmd_err}, 32'd0);
        nreset = 1'b1;
        repeat (4) @(negedge clk);

        // WREN then two-byte WRITE at 0x10
        cmd_only(8'h06);
        check_val("wren_wel", {31'd0, wel}, 32'd1);
        w0 = wr_cnt;
        spi_write(8'h10, 8'hA5, 8'h3C, 2);
        check_val("wr_pulses", w0 == 0 ? wr_cnt : wr_cnt - w0, 32'd2);
        check_val("wr_wel_clr", {31'd0, wel}, 32'd0);

        // READ back 0x10
        spi_read2(8'h03, 8'h10, r0, r1);
        check_val("rd_b0", {24'd0, r0}, 32'hA5);
        check_val("rd_b1", {24'd0, r1}, 32'h3C);
        check_val("rd_oe_data", {31'd0, oe_and}, 32'd1);
        check_val("rd_oe_idle", {31'd0, spi_miso_oe}, 32'd0);
        check_val("rd_miso_idle", {31'd0, spi_miso}, 32'd0);

        // Address wrap at MEM_DEPTH-1
        cmd_only(8'h06);
        spi_write(8'h7F, 8'h11, 8'h00, 1);
        cmd_only(8'h06);
        spi_write(8'h00, 8'h22, 8'h00, 1);
        spi_read2(8'h03, 8'h7F, r0, r1);
        check_val("wrap_b0", {24'd0, r0}, 32'h11);
        check_val("wrap_b1", {24'd0, r1}, 32'h22);
        spi_read2(8'h03, 8'hFF, r0, r1);
        check_val("mod_b0", {24'd0, r0}, 32'h11);
        check_val("mod_b1", {24'd0, r1}, 32'h22);

        // WREN followed by an extra bit must not set wel
        cs_begin();
        spi_xfer(8'h06, 8, rx);
        spi_xfer(8'h00, 1, rx);
        cs_end();
        check_val("wren9_wel", {31'd0, wel}, 32'd0);

        // WRITE without WREN
        w0 = wr_cnt;
        e0 = err_cnt;
        spi_write(8'h10, 8'h00, 8'h00, 1);
        check_val("nowel_err", err_cnt - e0, 32'd1);
        check_val("nowel_wr", wr_cnt - w0, 32'd0);
        spi_read2(8'h03, 8'h10, r0, r1);
        check_val("nowel_mem", {24'd0, r0}, 32'hA5);

        // Unsupported opcode
        e0 = err_cnt;
        cs_begin();
        spi_xfer(8'hFF, 8, rx);
        oe_or = 1'b0;
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_end();
        check_val("badop_err", err_cnt - e0, 32'd1);
        check_val("badop_oe", {31'd0, oe_or}, 32'd0);

        // RDSR with wel set, then cleared
        cmd_only(8'h06);
        spi_read2(8'h05, 8'h00, r0, r1);
        check_val("rdsr_wel1_a", {24'd0, r0}, 32'h02);
        check_val("rdsr_wel1_b", {24'd0, r1}, 32'h02);
        check_val("rdsr_oe", {31'd0, oe_and}, 32'd1);
        cmd_only(8'h04);
        spi_read2(8'h05, 8'h00, r0, r1);
        check_val("rdsr_wel0", {24'd0, r0}, 32'h00);
        check_val("wrdi_wel", {31'd0, wel}, 32'd0);

        // Abort after 5 data bits with nothing committed
        cmd_only(8'h06);
        w0 = wr_cnt;
        cs_begin();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h5A, 5, rx);
        cs_end();
        check_val("abort0_wr", wr_cnt - w0, 32'd0);
        check_val("abort0_wel", {31'd0, wel}, 32'd1);

        // Abort after one committed byte plus 5 bits
        w0 = wr_cnt;
        cs_begin();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h5A, 8, rx);
        spi_xfer(8'hC3, 5, rx);
        cs_end();
        check_val("abort1_wr", wr_cnt - w0, 32'd1);
        check_val("abort1_wel", {31'd0, wel}, 32'd0);
        spi_read2(8'h03, 8'h20, r0, r1);
        check_val("abort1_mem", {24'd0, r0}, 32'h5A);

        // nreset in the middle of a READ data phase
        cmd_only(8'h06);
        cs_begin();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'h00, 3, rx);
        check_val("mid_oe_pre", {31'd0, spi_miso_oe}, 32'd1);
        nreset = 1'b0;
        #1;
        check_val("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        check_val("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check_val("mid_rst_wel", {31'd0, wel}, 32'd0);
        #9;
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        spi_read2(8'h03, 8'h10, r0, r1);
        check_val("post_rst_b0", {24'd0, r0}, 32'hA5);
        check_val("post_rst_b1", {24'd0, r1}, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
